// File: rtl/divisor_sequencial_pkg.sv
// divisor_sequencial_pkg
//   Shared definitions for the sequential restoring divider:
//   - estado_t          : FSM state encoding (OCIOSO, CALCULO, FIM)
//   - N_PADRAO          : default operand/result width
//   - largura_contador  : width of the iteration counter for a given N
package divisor_sequencial_pkg;

    localparam int N_PADRAO = 4;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULO = 2'd1,
        FIM     = 2'd2
    } estado_t;

    // The counter is loaded with N and counts down to 0, so it must hold N.
    function automatic int largura_contador(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/divisor_sequencial_subtrator.sv
// divisor_sequencial_subtrator
//   Combinational W-bit subtractor, the dual of the multiplier's adder.
//   Ports:
//     a, b      : W-bit operands
//     diferenca : a - b, modulo 2^W
//     negativo  : sign bit of the result (set when a - b is negative)
module divisor_sequencial_subtrator
    import divisor_sequencial_pkg::*;
#(
    parameter int W = N_PADRAO + 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diferenca,
    output logic         negativo
);

    // The divider keeps its operands small enough that the MSB of the
    // difference is a reliable sign, so no separate borrow chain is needed.
    assign diferenca = a - b;
    assign negativo  = diferenca[W-1];

endmodule

// File: rtl/divisor_sequencial.sv
// divisor_sequencial
//   Sequential restoring divider: one quotient bit per clock.
//   Ports:
//     Clock      : system clock, rising edge
//     Reset_n    : asynchronous active-low reset
//     Inicio     : start request, sampled only while idle
//     Dividendo  : N-bit unsigned dividend, sampled with Inicio
//     Divisor    : N-bit unsigned divisor, sampled with Inicio
//     Ocupado    : high while iterating (state CALCULO)
//     Pronto     : one-cycle pulse, results valid
//     Quociente  : registered quotient
//     Resto      : registered remainder
//     DivZero    : registered divide-by-zero flag
module divisor_sequencial
    import divisor_sequencial_pkg::*;
#(
    parameter int N = N_PADRAO
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         Inicio,
    input  logic [N-1:0] Dividendo,
    input  logic [N-1:0] Divisor,
    output logic         Ocupado,
    output logic         Pronto,
    output logic [N-1:0] Quociente,
    output logic [N-1:0] Resto,
    output logic         DivZero
);

    localparam int            CW      = largura_contador(N);
    localparam logic [CW-1:0] CNT_INI = CW'(N);
    localparam logic [CW-1:0] CNT_ULT = CW'(1);

    estado_t       estado;
    estado_t       proximo;
    logic [N:0]    r;
    logic [N:0]    t;
    logic [N:0]    s;
    logic [N:0]    r_novo;
    logic [N-1:0]  q;
    logic [N-1:0]  d;
    logic [N-1:0]  q_novo;
    logic [CW-1:0] cnt;
    logic          negativo;
    logic          divisor_zero;

    assign divisor_zero = (Divisor == '0);

    // Shift the next dividend bit into the partial remainder. R stays below
    // D, so its top bit is always 0 and dropping it in the shift is lossless.
    assign t = (r << 1) | {{N{1'b0}}, q[N-1]};

    divisor_sequencial_subtrator #(
        .W(N + 1)
    ) u_subtrator (
        .a        (t),
        .b        ({1'b0, d}),
        .diferenca(s),
        .negativo (negativo)
    );

    // Restoring step: keep the difference only when it did not go negative.
    assign r_novo = negativo ? t : s;
    assign q_novo = {q[N-2:0], ~negativo};

    assign Ocupado = (estado == CALCULO);
    assign Pronto  = (estado == FIM);

    // State register; reset aborts any division in progress.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state logic. A zero divisor skips the iteration and goes
    // straight to FIM, so Pronto appears the cycle after the start edge.
    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO: begin
                if (Inicio) begin
                    proximo = divisor_zero ? FIM : CALCULO;
                end
            end
            CALCULO: begin
                if (cnt == CNT_ULT) begin
                    proximo = FIM;
                end
            end
            FIM:     proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    // Datapath and result registers. Results are written only on the last
    // iteration (or directly for divide-by-zero) and otherwise hold.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r         <= '0;
            q         <= '0;
            d         <= '0;
            cnt       <= '0;
            Quociente <= '0;
            Resto     <= '0;
            DivZero   <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (Inicio) begin
                        if (divisor_zero) begin
                            Quociente <= '1;
                            Resto     <= Dividendo;
                            DivZero   <= 1'b1;
                        end else begin
                            q   <= Dividendo;
                            d   <= Divisor;
                            r   <= '0;
                            cnt <= CNT_INI;
                        end
                    end
                end
                CALCULO: begin
                    r   <= r_novo;
                    q   <= q_novo;
                    cnt <= cnt - CNT_ULT;
                    if (cnt == CNT_ULT) begin
                        Quociente <= q_novo;
                        Resto     <= r_novo[N-1:0];
                        DivZero   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_sequencial.sv
// tb_divisor_sequencial
//   Directed self-checking bench for divisor_sequencial (N = 4).
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_divisor_sequencial;

    logic       Clock;
    logic       Reset_n;
    logic       Inicio;
    logic [3:0] Dividendo;
    logic [3:0] Divisor;
    logic       Ocupado;
    logic       Pronto;
    logic [3:0] Quociente;
    logic [3:0] Resto;
    logic       DivZero;

    int compared   = 0;
    int mismatched = 0;

    divisor_sequencial #(
        .N(4)
    ) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Inicio   (Inicio),
        .Dividendo(Dividendo),
        .Divisor  (Divisor),
        .Ocupado  (Ocupado),
        .Pronto   (Pronto),
        .Quociente(Quociente),
        .Resto    (Resto),
        .DivZero  (DivZero)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Absolute time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Waits for Pronto starting at cycle k0 (cycle 1 = the cycle after the
    // start edge). Returns the cycle Pronto was seen (-1 on timeout), how
    // many cycles Ocupado was high and how often Ocupado and Pronto overlapped.
    task automatic wait_pronto(input int k0, output int lat, output int busy, output int overlap);
        lat     = -1;
        busy    = 0;
        overlap = 0;
        for (int k = k0; k <= k0 + 20; k++) begin
            if (Ocupado) busy++;
            if (Ocupado && Pronto) overlap++;
            if (Pronto) begin
                lat = k;
                break;
            end
            @(negedge Clock);
        end
    endtask

    // Moves to the next cycle, pulses Inicio for one cycle with the given
    // operands and waits for Pronto.
    task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                           output int lat, output int busy, output int overlap);
        @(negedge Clock);
        Inicio    = 1'b1;
        Dividendo = a;
        Divisor   = b;
        @(negedge Clock);
        Inicio = 1'b0;
        wait_pronto(1, lat, busy, overlap);
    endtask

    task automatic test_reset();
        Reset_n   = 1'b0;
        Inicio    = 1'b0;
        Dividendo = 4'd0;
        Divisor   = 4'd0;
        @(negedge Clock);
        @(negedge Clock);
        compared++;
        if ({Ocupado, Pronto, Quociente, Resto, DivZero} !== 11'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %b expected all zero",
                     {Ocupado, Pronto, Quociente, Resto, DivZero});
        end
        Reset_n = 1'b1;
        @(negedge Clock);
        compared++;
        if ({Ocupado, Pronto} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL idle_after_reset: got %b expected 00", {Ocupado, Pronto});
        end
    endtask

    task automatic test_basic();
        int lat, busy, overlap;
        run_div(4'd13, 4'd3, lat, busy, overlap);
        compared++;
        if (lat !== 5) begin
            mismatched++;
            $display("[TB] FAIL basic_latency: got %0d expected 5", lat);
        end
        compared++;
        if (busy !== 4 || overlap !== 0) begin
            mismatched++;
            $display("[TB] FAIL basic_busy: got busy=%0d overlap=%0d expected busy=4 overlap=0", busy, overlap);
        end
        compared++;
        if ({Quociente, Resto, DivZero} !== {4'd4, 4'd1, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL basic_13_3: got Q=%0d R=%0d DZ=%0d expected Q=4 R=1 DZ=0",
                     Quociente, Resto, DivZero);
        end
        @(negedge Clock);
        compared++;
        if (Pronto !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_pronto_width: got %b expected 0", Pronto);
        end
    endtask

    task automatic test_hold();
        int lat, busy, overlap;
        run_div(4'd15, 4'd1, lat, busy, overlap);
        compared++;
        if ({Quociente, Resto} !== {4'd15, 4'd0} || lat !== 5) begin
            mismatched++;
            $display("[TB] FAIL hold_15_1: got Q=%0d R=%0d lat=%0d expected Q=15 R=0 lat=5",
                     Quociente, Resto, lat);
        end
        repeat (3) @(negedge Clock);
        compared++;
        if ({Quociente, Resto, Pronto, Ocupado} !== {4'd15, 4'd0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL hold_idle: got Q=%0d R=%0d P=%b O=%b expected Q=15 R=0 P=0 O=0",
                     Quociente, Resto, Pronto, Ocupado);
        end
        run_div(4'd3, 4'd7, lat, busy, overlap);
        compared++;
        if ({Quociente, Resto, DivZero} !== {4'd0, 4'd3, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL hold_3_7: got Q=%0d R=%0d DZ=%0d expected Q=0 R=3 DZ=0",
                     Quociente, Resto, DivZero);
        end
    endtask

    task automatic test_divzero();
        int lat, busy, overlap;
        run_div(4'd9, 4'd0, lat, busy, overlap);
        compared++;
        if (lat !== 1 || busy !== 0) begin
            mismatched++;
            $display("[TB] FAIL divzero_timing: got lat=%0d busy=%0d expected lat=1 busy=0", lat, busy);
        end
        compared++;
        if ({Quociente, Resto, DivZero} !== {4'd15, 4'd9, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL divzero_9_0: got Q=%0d R=%0d DZ=%0d expected Q=15 R=9 DZ=1",
                     Quociente, Resto, DivZero);
        end
        run_div(4'd8, 4'd2, lat, busy, overlap);
        compared++;
        if ({Quociente, Resto, DivZero} !== {4'd4, 4'd0, 1'b0} || lat !== 5) begin
            mismatched++;
            $display("[TB] FAIL divzero_clear_8_2: got Q=%0d R=%0d DZ=%0d lat=%0d expected Q=4 R=0 DZ=0 lat=5",
                     Quociente, Resto, DivZero, lat);
        end
    endtask

    task automatic test_ignored_start();
        int lat, busy, overlap;
        int extra;
        @(negedge Clock);
        Inicio    = 1'b1;
        Dividendo = 4'd14;
        Divisor   = 4'd5;
        @(negedge Clock);
        Inicio = 1'b0;
        @(negedge Clock);
        compared++;
        if (Ocupado !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ignored_busy: got %b expected 1", Ocupado);
        end
        Inicio    = 1'b1;
        Dividendo = 4'd3;
        Divisor   = 4'd1;
        @(negedge Clock);
        Inicio = 1'b0;
        wait_pronto(3, lat, busy, overlap);
        compared++;
        if ({Quociente, Resto} !== {4'd2, 4'd4} || lat !== 5 || overlap !== 0) begin
            mismatched++;
            $display("[TB] FAIL ignored_14_5: got Q=%0d R=%0d lat=%0d ov=%0d expected Q=2 R=4 lat=5 ov=0",
                     Quociente, Resto, lat, overlap);
        end
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clock);
            if (Pronto || Ocupado) extra++;
        end
        compared++;
        if (extra !== 0) begin
            mismatched++;
            $display("[TB] FAIL ignored_single_pronto: got %0d extra active cycles expected 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int lat, busy, overlap;
        int stray;
        @(negedge Clock);
        Inicio    = 1'b1;
        Dividendo = 4'd12;
        Divisor   = 4'd5;
        @(negedge Clock);
        Inicio = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b0;
        #1;
        compared++;
        if ({Ocupado, Pronto, Quociente, Resto, DivZero} !== 11'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_outputs: got %b expected all zero",
                     {Ocupado, Pronto, Quociente, Resto, DivZero});
        end
        @(negedge Clock);
        Reset_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clock);
            if (Pronto || Ocupado) stray++;
        end
        compared++;
        if (stray !== 0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_no_pronto: got %0d active cycles expected 0", stray);
        end
        run_div(4'd7, 4'd2, lat, busy, overlap);
        compared++;
        if ({Quociente, Resto, DivZero} !== {4'd3, 4'd1, 1'b0} || lat !== 5) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_7_2: got Q=%0d R=%0d DZ=%0d lat=%0d expected Q=3 R=1 DZ=0 lat=5",
                     Quociente, Resto, DivZero, lat);
        end
    endtask

    task automatic test_sweep();
        int lat, busy, overlap;
        logic [3:0] eq, er;
        logic       edz;
        int         elat;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                if (j == 0) begin
                    eq   = 4'd15;
                    er   = 4'(i);
                    edz  = 1'b1;
                    elat = 1;
                end else begin
                    eq   = 4'(i / j);
                    er   = 4'(i % j);
                    edz  = 1'b0;
                    elat = 5;
                end
                run_div(4'(i), 4'(j), lat, busy, overlap);
                compared++;
                if ({Quociente, Resto, DivZero} !== {eq, er, edz} || lat !== elat || overlap !== 0) begin
                    mismatched++;
                    $display("[TB] FAIL sweep_%0d_%0d: got Q=%0d R=%0d DZ=%0d lat=%0d ov=%0d expected Q=%0d R=%0d DZ=%0d lat=%0d ov=0",
                             i, j, Quociente, Resto, DivZero, lat, overlap, eq, er, edz, elat);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_divzero();
        test_ignored_start();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/divisor_sequencial.md
Name: divisor_sequencial

Overview:
Sequential restoring divider. It is the inverse datapath of the shift-and-add multiplier and is built on an (N+1)-bit subtractor, the counterpart of the existing adder. It takes an unsigned N-bit dividend and divisor on a start pulse and iterates one quotient bit per clock. It returns the quotient and remainder with a one-cycle done pulse and flags division by zero.

Parameters:
N, 4, operand/result width in bits (N >= 2)

Ports:
Clock  input  1  system clock; all state updates on rising edge
Reset_n  input  1  asynchronous, active-low reset
Inicio  input  1  start request; sampled only in state OCIOSO
Dividendo  input  N  unsigned dividend; sampled with Inicio
Divisor  input  N  unsigned divisor; sampled with Inicio
Ocupado  output  1  high while a division is in progress (state CALCULO)
Pronto  output  1  one-cycle pulse; results valid and updated
Quociente  output  N  unsigned quotient, registered
Resto  output  N  unsigned remainder, registered
DivZero  output  1  high with/after Pronto when the divisor was 0; registered

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset (Reset_n=0, any time, including mid-operation):
  - State goes to OCIOSO.
  - Ocupado, Pronto, Quociente, Resto and DivZero are all 0.
  - Internal registers (partial remainder, shift register, counter) are cleared.
  - An interrupted division produces no Pronto.
- FSM states: OCIOSO, CALCULO, FIM.
- OCIOSO:
  - Inicio=1 with Divisor!=0:
    - Latch Dividendo into the shift register Q and Divisor into D.
    - Clear the partial remainder R (N+1 bits) and set the counter to N.
    - Go to CALCULO.
  - Inicio=1 with Divisor=0: go to FIM with Quociente = all ones, Resto = Dividendo, DivZero = 1.
  - Inicio=0: stay.
- CALCULO: one iteration per clock.
  - T = {R[N-1:0], Q[N-1]}.
  - S = T - {1'b0, D}, computed as an (N+1)-bit subtraction.
  - If S[N]=0 (non-negative): R <= S and Q <= {Q[N-2:0], 1}.
  - Otherwise: R <= T and Q <= {Q[N-2:0], 0}.
  - Counter decrements. On the iteration where the counter reaches 0:
    - Quociente <= new Q, Resto <= new R[N-1:0], DivZero <= 0.
    - Go to FIM.
- FIM: Pronto=1 for exactly this one cycle, then unconditionally OCIOSO.
- Latency, with start edge = the edge sampling Inicio in OCIOSO:
  - Normal case: Ocupado is high for N cycles after the start edge. Pronto is high in cycle N+1, i.e. after edge N+1 relative to the start edge.
  - Divide by zero: Pronto is high in the cycle after the start edge.
- Ocupado = (state == CALCULO). Ocupado and Pronto are never high together.
- Inicio during CALCULO or FIM is ignored; there is no queuing. A new start is accepted from the first OCIOSO cycle. Back-to-back throughput is one division per N+2 cycles.
- Quociente, Resto and DivZero hold their last values until the next result is written. They are not cleared at start.
- Dividendo and Divisor may change freely after the start edge without affecting the result.
- Arithmetic:
  - R never exceeds D-1 after an iteration.
  - Result invariant: Dividendo = Quociente*Divisor + Resto, with Resto < Divisor.

Decomposition:
- Shared package/include holds:
  - State encoding constants OCIOSO=2'd0, CALCULO=2'd1, FIM=2'd2.
  - Default width N=4.
  - Counter width $clog2(N+1).
- One sub-module, subtrator: combinational (N+1)-bit A-B with a borrow/sign output, the dual of the adder.
- The FSM and datapath registers stay in divisor_sequencial.

Test Plan:
1. Reset_n=0, then release; 13/3 with a one-cycle Inicio -> Ocupado high for 4 cycles, then Pronto for 1 cycle with Quociente=4, Resto=1, DivZero=0.
2. 15/1 and 3/7 -> Q=15, R=0; then Q=0, R=3. Outputs hold between operations.
3. 9/0 -> Pronto the cycle after the start edge, Quociente=15, Resto=9, DivZero=1, Ocupado never high. Then 8/2 -> Q=4, R=0, DivZero back to 0.
4. Start 14/5; change operands and pulse Inicio during CALCULO -> second Inicio ignored, result Q=2, R=4, exactly one Pronto.
5. Start 12/5; drop Reset_n asynchronously at the 2nd CALCULO cycle -> all outputs 0 immediately, no Pronto. After release, 7/2 -> Q=3, R=1.
6. Exhaustive sweep of all Dividendo 0..15 × Divisor 0..15, restarting on the cycle after each Pronto:
   - Divisor != 0 -> Quociente == i/j, Resto == i%j, latency always N+1 cycles.
   - Divisor = 0 -> DivZero=1, Quociente=15, Resto=i.
